// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the divided-clock monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE
  } state_t;

  localparam int                   ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/edge_detect.sv
// Two-flop sampler for the divided clock; flags the cycle after a 0->1 transition.
module edge_detect (
  input  logic clk_in,
  input  logic rst,
  input  logic div_in,
  output logic div_q,
  output logic rise
);

  logic div_qq;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      div_q  <= 1'b0;
      div_qq <= 1'b0;
    end else begin
      div_q  <= div_in;
      div_qq <= div_q;
    end
  end

  assign rise = div_q & ~div_qq;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock sampled in the clk_in domain
// and reports per-measurement errors, lock and stuck status.
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int EXP_PERIOD = 28,
  parameter int EXP_HIGH   = 14,
  parameter int CNT_W      = 8,
  parameter int LOCK_COUNT = 4
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 div_in,
  output logic                 meas_valid,
  output logic [CNT_W-1:0]     period_out,
  output logic [CNT_W-1:0]     high_out,
  output logic                 period_err,
  output logic                 duty_err,
  output logic                 stuck,
  output logic                 locked,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int               GOOD_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] EXP_P    = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] EXP_H    = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] TIMEOUT  = CNT_W'(2 * EXP_PERIOD);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_COUNT);

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc_err(input logic [ERR_CNT_W-1:0] v);
    return (v == ERR_CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [GOOD_W-1:0] sat_inc_good(input logic [GOOD_W-1:0] v);
    return (v == GOOD_MAX) ? v : v + 1'b1;
  endfunction

  logic              div_q;
  logic              rise;
  logic [CNT_W-1:0]  run_cnt;
  logic [CNT_W-1:0]  high_acc;
  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] good_next;
  state_t            state_q;
  state_t            state_d;
  logic              capture;
  logic              timeout;
  logic              p_bad;
  logic              d_bad;

  edge_detect u_edge (
    .clk_in (clk_in),
    .rst    (rst),
    .div_in (div_in),
    .div_q  (div_q),
    .rise   (rise)
  );

  // Stage 0: free-running period and high-time counters, restarted on every rise
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      run_cnt  <= '0;
      high_acc <= '0;
    end else if (rise) begin
      run_cnt  <= CNT_ONE;
      high_acc <= CNT_ONE;
    end else begin
      run_cnt  <= sat_inc_cnt(run_cnt);
      if (div_q) high_acc <= sat_inc_cnt(high_acc);
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // The first rise only arms the FSM: the counters have no full period behind them yet
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) state_d = ARMED;
      end
      ARMED, MEASURE: begin
        if (rise) begin
          capture = 1'b1;
          state_d = MEASURE;
        end else if (run_cnt == TIMEOUT) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign p_bad     = (run_cnt != EXP_P);
  assign d_bad     = (high_acc != EXP_H);
  assign good_next = sat_inc_good(good_cnt);

  // Stage 1: registered measurement, error flags and lock/stuck status
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      meas_valid <= 1'b0;
      period_out <= '0;
      high_out   <= '0;
      period_err <= 1'b0;
      duty_err   <= 1'b0;
      stuck      <= 1'b0;
      locked     <= 1'b0;
      err_count  <= '0;
      good_cnt   <= '0;
    end else begin
      meas_valid <= capture;
      if (capture) begin
        period_out <= run_cnt;
        high_out   <= high_acc;
        period_err <= p_bad;
        duty_err   <= d_bad;
        if (p_bad || d_bad) begin
          err_count <= sat_inc_err(err_count);
          good_cnt  <= '0;
          locked    <= 1'b0;
        end else begin
          good_cnt  <= good_next;
          locked    <= (good_next == GOOD_MAX);
        end
      end else if (timeout) begin
        good_cnt <= '0;
        locked   <= 1'b0;
      end
      if (rise)         stuck <= 1'b0;
      else if (timeout) stuck <= 1'b1;
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: three configurations share one div_in and are checked
// every cycle against a timestamp-based model, plus directed literal checks.
module tb_clk_div_monitor;

  localparam int N  = 3;
  localparam int LC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic div = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       mv   [N];
  logic [7:0] per  [N];
  logic [7:0] hi   [N];
  logic       perr [N];
  logic       derr [N];
  logic       stk  [N];
  logic       lck  [N];
  logic [7:0] errc [N];

  clk_div_monitor #(.EXP_PERIOD(28), .EXP_HIGH(14), .CNT_W(8), .LOCK_COUNT(4)) u0 (
    .clk_in(clk), .rst(rst), .div_in(div), .meas_valid(mv[0]), .period_out(per[0]),
    .high_out(hi[0]), .period_err(perr[0]), .duty_err(derr[0]), .stuck(stk[0]),
    .locked(lck[0]), .err_count(errc[0]));

  clk_div_monitor #(.EXP_PERIOD(5), .EXP_HIGH(2), .CNT_W(8), .LOCK_COUNT(4)) u1 (
    .clk_in(clk), .rst(rst), .div_in(div), .meas_valid(mv[1]), .period_out(per[1]),
    .high_out(hi[1]), .period_err(perr[1]), .duty_err(derr[1]), .stuck(stk[1]),
    .locked(lck[1]), .err_count(errc[1]));

  clk_div_monitor #(.EXP_PERIOD(2), .EXP_HIGH(1), .CNT_W(8), .LOCK_COUNT(4)) u2 (
    .clk_in(clk), .rst(rst), .div_in(div), .meas_valid(mv[2]), .period_out(per[2]),
    .high_out(hi[2]), .period_err(perr[2]), .duty_err(derr[2]), .stuck(stk[2]),
    .locked(lck[2]), .err_count(errc[2]));

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
  endtask

  function automatic int ep_of(input int i);
    return (i == 0) ? 28 : (i == 1) ? 5 : 2;
  endfunction

  function automatic int eh_of(input int i);
    return (i == 0) ? 14 : (i == 1) ? 2 : 1;
  endfunction

  function automatic int clamp255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Model: rises are timestamped by clock edge; a measurement is the distance
  // between consecutive rise timestamps and the number of high samples between them.
  int   m_arm   [N];
  int   m_rlast [N];
  int   m_ones  [N];
  int   m_good  [N];
  int   m_errc  [N];
  int   m_per   [N];
  int   m_hi    [N];
  logic m_mv    [N];
  logic m_perr  [N];
  logic m_derr  [N];
  logic m_stk   [N];
  logic m_lck   [N];
  logic h1, h2;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_arm[i] = 0; m_rlast[i] = 0; m_ones[i] = 0; m_good[i] = 0; m_errc[i] = 0;
      m_per[i] = 0; m_hi[i] = 0; m_mv[i] = 1'b0; m_perr[i] = 1'b0; m_derr[i] = 1'b0;
      m_stk[i] = 1'b0; m_lck[i] = 1'b0;
    end
    h1 = 1'b0;
    h2 = 1'b0;
  endtask

  task automatic model_step();
    int p;
    int hv;
    for (int i = 0; i < N; i++) begin
      m_mv[i] = 1'b0;
      if (h1 && !h2) begin
        if (m_arm[i] > 0) begin
          p  = clamp255(cyc - 1 - m_rlast[i]);
          hv = clamp255(m_ones[i]);
          m_mv[i]   = 1'b1;
          m_per[i]  = p;
          m_hi[i]   = hv;
          m_perr[i] = (p != ep_of(i));
          m_derr[i] = (hv != eh_of(i));
          if (m_perr[i] || m_derr[i]) begin
            m_errc[i] = clamp255(m_errc[i] + 1);
            m_good[i] = 0;
            m_lck[i]  = 1'b0;
          end else begin
            m_good[i] = (m_good[i] + 1 > LC) ? LC : m_good[i] + 1;
            m_lck[i]  = (m_good[i] == LC);
          end
        end
        m_stk[i] = 1'b0;
        if (m_arm[i] < 2) m_arm[i]++;
        m_rlast[i] = cyc - 1;
        m_ones[i]  = 0;
      end else if (m_arm[i] > 0 && (cyc - 1 - m_rlast[i]) == 2 * ep_of(i)) begin
        m_stk[i]  = 1'b1;
        m_lck[i]  = 1'b0;
        m_good[i] = 0;
        m_arm[i]  = 0;
      end
      if (h1) m_ones[i]++;
    end
    h2 = h1;
    h1 = div;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  function automatic logic [63:0] pack_dut(input int i);
    return {35'd0, mv[i], per[i], hi[i], perr[i], derr[i], stk[i], lck[i], errc[i]};
  endfunction

  function automatic logic [63:0] pack_model(input int i);
    return {35'd0, m_mv[i], 8'(m_per[i]), 8'(m_hi[i]), m_perr[i], m_derr[i],
            m_stk[i], m_lck[i], 8'(m_errc[i])};
  endfunction

  int mv_cnt    [N];
  int first_mv  [N];
  int mv_at_lock[N];

  initial begin
    for (int i = 0; i < N; i++) begin
      mv_cnt[i] = 0; first_mv[i] = 0; mv_at_lock[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        check($sformatf("model_u%0d_cyc%0d", i, cyc), pack_dut(i), pack_model(i));
        if (rst) begin
          mv_cnt[i] = 0; first_mv[i] = 0; mv_at_lock[i] = 0;
        end else begin
          if (mv[i]) mv_cnt[i]++;
          if (mv[i] && first_mv[i] == 0) first_mv[i] = cyc;
          if (lck[i] && mv_at_lock[i] == 0) mv_at_lock[i] = mv_cnt[i];
        end
      end
    end
  end

  task automatic look();
    #1;
  endtask

  task automatic drive_bit(input logic v);
    @(negedge clk);
    div = v;
  endtask

  task automatic pulses(input int h, input int l, input int n);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < h; j++) drive_bit(1'b1);
      for (int j = 0; j < l; j++) drive_bit(1'b0);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    #2;
    rst = 1'b1;
    div = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t0;
    int n;
    int mv0;

    reset_dut();
    look();
    for (int i = 0; i < N; i++) check($sformatf("reset_u%0d", i), pack_dut(i), 64'd0);

    // 14/14 pattern on the default configuration
    t0 = cyc;
    pulses(14, 14, 6);
    look();
    check("t1_first_latency", 64'(first_mv[0] - t0), 64'd31);
    check("t1_period", 64'(per[0]), 64'd28);
    check("t1_high", 64'(hi[0]), 64'd14);
    check("t1_errflags", {62'd0, perr[0], derr[0]}, 64'd0);
    check("t1_locked", 64'(lck[0]), 64'd1);
    check("t1_mv_at_lock", 64'(mv_at_lock[0]), 64'd4);

    // EXP_PERIOD=5: lock, one bad duty period, relock
    reset_dut();
    pulses(2, 3, 6);
    look();
    check("t2_locked", 64'(lck[1]), 64'd1);
    check("t2_period", 64'(per[1]), 64'd5);
    check("t2_high", 64'(hi[1]), 64'd2);
    pulses(3, 2, 1);
    pulses(2, 3, 1);
    look();
    check("t2_duty_err", 64'(derr[1]), 64'd1);
    check("t2_period_err", 64'(perr[1]), 64'd0);
    check("t2_unlocked", 64'(lck[1]), 64'd0);
    check("t2_err_count", 64'(errc[1]), 64'd1);
    pulses(2, 3, 4);
    look();
    check("t2_relocked", 64'(lck[1]), 64'd1);

    // Stuck input after lock, then recovery
    reset_dut();
    pulses(14, 14, 6);
    look();
    check("t3_locked_before", 64'(lck[0]), 64'd1);
    t0 = cyc;
    n = 0;
    while (!stk[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    look();
    check("t3_stuck_time", 64'(cyc - t0), 64'd31);
    check("t3_stuck_unlock", {62'd0, stk[0], lck[0]}, 64'd2);
    mv0 = mv_cnt[0];
    pulses(14, 14, 1);
    look();
    check("t3_stuck_clear", 64'(stk[0]), 64'd0);
    check("t3_no_mv_first_rise", 64'(mv_cnt[0]), 64'(mv0));
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    look();
    check("t3_mv_second_rise", 64'(mv_cnt[0]), 64'(mv0 + 1));
    check("t3_period", 64'(per[0]), 64'd28);

    // 27-cycle periods saturate the error counter
    reset_dut();
    pulses(14, 13, 300);
    look();
    check("t4_err_sat", 64'(errc[0]), 64'd255);
    check("t4_flags", {62'd0, perr[0], derr[0]}, 64'd2);

    // Asynchronous reset mid-period after lock
    reset_dut();
    pulses(14, 14, 6);
    for (int j = 0; j < 7; j++) drive_bit(1'b1);
    look();
    check("t5_locked_before", 64'(lck[0]), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) check($sformatf("t5_async_u%0d", i), pack_dut(i), 64'd0);
    @(negedge clk);
    div = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    pulses(14, 14, 1);
    look();
    check("t5_no_mv_first_rise", 64'(mv_cnt[0]), 64'd0);
    pulses(14, 14, 1);
    look();
    check("t5_mv_second_rise", 64'(mv_cnt[0]), 64'd1);

    // Divide-by-2 input on EXP_PERIOD=2
    reset_dut();
    pulses(1, 1, 12);
    drive_bit(1'b0);
    look();
    check("t6_mv_count", 64'(mv_cnt[2]), 64'd11);
    check("t6_period", 64'(per[2]), 64'd2);
    check("t6_high", 64'(hi[2]), 64'd1);
    check("t6_locked", 64'(lck[2]), 64'd1);
    check("t6_mv_at_lock", 64'(mv_at_lock[2]), 64'd4);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Downstream checker for the clock divider's outputs. It samples one divided clock (clk_div_2 … clk_div_28, clk_div_5) as a data signal in the clk_in domain. For each cycle of that divided clock it measures the period and the high time in clk_in cycles, compares both against parameterised expectations, and reports lock, error and stuck status for bring-up and self-test.

## Interface

Parameters:
- EXP_PERIOD, 28, expected period in clk_in cycles (2..127 when CNT_W=8)
- EXP_HIGH, 14, expected high time in clk_in cycles (1..EXP_PERIOD-1)
- CNT_W, 8, width of the measurement counters
- LOCK_COUNT, 4, consecutive good measurements required to assert locked

Ports:
- clk_in  in  1  system clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- div_in  in  1  divided clock under test, sampled as data
- meas_valid  out  1  one-cycle pulse; a new measurement is on period_out/high_out
- period_out  out  CNT_W  last measured period, rise to rise
- high_out  out  CNT_W  last measured high time
- period_err  out  1  period_out != EXP_PERIOD; updated with meas_valid
- duty_err  out  1  high_out != EXP_HIGH; updated with meas_valid
- stuck  out  1  no rising edge within 2*EXP_PERIOD cycles
- locked  out  1  LOCK_COUNT consecutive error-free measurements
- err_count  out  8  count of bad measurements, saturating at 255

## Operation

- Sampling:
  - div_in is registered into div_q, then into div_qq.
  - rise = div_q & ~div_qq.
- run_cnt:
  - Set to 1 on rise; otherwise increments.
  - Saturates at 2^CNT_W-1.
- high_acc:
  - Set to 1 on rise.
  - Otherwise increments when div_q=1 and holds when div_q=0.
  - Saturates at 2^CNT_W-1.
- FSM states IDLE, ARMED, MEASURE:
  - IDLE, on rise: go to ARMED. No capture.
  - ARMED, on rise: capture and go to MEASURE.
  - MEASURE, on rise: capture and stay in MEASURE.
  - ARMED or MEASURE, when run_cnt == 2*EXP_PERIOD with no rise: go to IDLE. Set stuck=1, locked=0, and clear the good-run counter.
  - stuck clears on the next rise.
- Capture:
  - period_out <= run_cnt and high_out <= high_acc; meas_valid=1.
  - period_err and duty_err are computed from the captured values and registered in the same cycle.
- Bad measurement (period_err | duty_err):
  - err_count += 1, saturating.
  - good-run counter <= 0; locked <= 0.
- Good measurement:
  - good-run counter += 1, saturating at LOCK_COUNT.
  - locked <= 1 when the counter reaches LOCK_COUNT.
- Simultaneous rise and timeout: rise wins and is captured normally; the timeout is ignored.
- A stuck event does not increment err_count.

## Timing

- Reset values (asynchronous, immediate):
  - Every output is 0, including period_out, high_out and err_count.
  - FSM is in IDLE.
  - div_q, div_qq, run_cnt, high_acc and the good-run counter are 0.
- Latency: div_in goes high after clk_in edge k → meas_valid, period_out, high_out and the error flags are valid after edge k+2.
- The first measurement appears at the second rising edge after reset or after a stuck event.
- meas_valid is exactly one cycle wide. Minimum spacing is 2 cycles (div-by-2 input).
- period_out, high_out, period_err and duty_err hold their values between captures.
- locked updates in the same cycle as the meas_valid that completes or breaks the run.
- stuck is set in the cycle run_cnt reaches 2*EXP_PERIOD.
- Reset asserted mid-period aborts the measurement; no partial capture is made.

## Structure

- Package clk_mon_pkg holds:
  - state typedef (IDLE, ARMED, MEASURE)
  - ERR_CNT_W = 8 and ERR_CNT_MAX = 255
- Sub-module edge_detect holds the two sampling flops and produces rise and div_q.
- The top level holds the counters, FSM and status logic.

## Test plan

- Defaults, 14-high/14-low pattern on div_in:
  - meas_valid at the second rise, period_out=28, high_out=14, no errors.
  - locked=1 on the 4th meas_valid.
- EXP_PERIOD=5, EXP_HIGH=2:
  - 2-high/3-low pattern → period 5, high 2, locks.
  - Then one 3-high/2-low period → duty_err=1, period_err=0, locked=0, err_count=1.
  - Relocks after 4 good periods.
- Defaults, after lock, hold div_in low:
  - stuck=1 when run_cnt=56, locked=0, FSM in IDLE.
  - Resume toggling: stuck clears on the first rise; next meas_valid only at the second rise.
- Defaults, 27-cycle periods:
  - period_err=1 on every measurement.
  - After 300 periods, err_count=255 and holds.
- Assert rst between clk_in edges mid-period after lock:
  - All outputs drop to 0 immediately.
  - After release, the first measurement comes two rises later.
- EXP_PERIOD=2, EXP_HIGH=1, div_in toggling every cycle:
  - meas_valid every 2nd cycle with period 2, high 1.
  - locked after 4 measurements.
